// File: rtl/inst_fetcher_pkg.sv
// Shared types for the fetch stage: FSM states and the instruction-queue entry.
package inst_fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/inst_queue.sv
// Circular show-ahead instruction FIFO; head outputs come only from registered state.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int IQ_DEPTH_LOG = 3
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      i_en,
    input  logic      i_push,
    input  iq_entry_t i_push_entry,
    input  logic      i_pop,
    input  logic      i_clear,
    input  logic      i_pending,
    output logic      o_full,
    output logic      o_valid,
    output iq_entry_t o_head
);

    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG+1:0] DEPTH_W = (IQ_DEPTH_LOG+2)'(DEPTH);
    localparam logic [IQ_DEPTH_LOG:0]   ONE     = (IQ_DEPTH_LOG+1)'(1);

    iq_entry_t                 r_mem [DEPTH];
    logic [IQ_DEPTH_LOG-1:0]   r_head;
    logic [IQ_DEPTH_LOG-1:0]   r_tail;
    logic [IQ_DEPTH_LOG:0]     r_count;

    logic                      w_do_push;
    logic                      w_do_pop;
    logic [IQ_DEPTH_LOG+1:0]   w_occupancy;

    // Clear wins over push and pop; a pop on an empty queue is dropped.
    assign w_do_pop    = i_en && !i_clear && i_pop && (r_count != '0);
    assign w_do_push   = i_en && !i_clear && i_push;
    assign w_occupancy = {1'b0, r_count} + {{(IQ_DEPTH_LOG+1){1'b0}}, i_pending};
    assign o_full      = (w_occupancy >= DEPTH_W);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_do_push) r_tail <= r_tail + 1'b1;
                if (w_do_pop)  r_head <= r_head + 1'b1;
                if (w_do_push && !w_do_pop)      r_count <= r_count + ONE;
                else if (w_do_pop && !w_do_push) r_count <= r_count - ONE;
            end
        end
    end

    // NOTE: storage is left unreset; the valid count alone decides what is visible.
    always_ff @(posedge clk_in) begin
        if (w_do_push) r_mem[r_tail] <= i_push_entry;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_head] : '0;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: sequential-PC request FSM feeding the instruction queue,
// with redirect that flushes the queue and discards an in-flight read.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    input  logic        iq_pop,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;

    logic         w_pending;
    logic         w_push;
    logic         w_full;
    iq_entry_t    w_push_entry;
    iq_entry_t    w_head;

    assign w_pending         = (r_state == WAIT_MEM);
    assign w_push            = (r_state == WAIT_MEM) && mem_done && !flush;
    assign w_push_entry.inst = mem_data;
    assign w_push_entry.pc   = r_mem_addr;

    inst_queue #(
        .IQ_DEPTH_LOG (IQ_DEPTH_LOG)
    ) u_queue (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .i_en         (rdy_in),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (iq_pop),
        .i_clear      (flush),
        .i_pending    (w_pending),
        .o_full       (w_full),
        .o_valid      (iq_valid),
        .o_head       (w_head)
    );

    // NOTE: non-blocking assignments so every decision below sees pre-edge state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (rdy_in) begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                    end else if (!w_full) begin
                        r_state    <= WAIT_MEM;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end
                end
                WAIT_MEM: begin
                    if (mem_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_pc      <= flush ? flush_pc : r_pc + PC_STEP;
                    end else if (flush) begin
                        // The controller cannot abort: keep the request up and drop its data later.
                        r_state <= DISCARD;
                        r_pc    <= flush_pc;
                    end
                end
                DISCARD: begin
                    if (flush) r_pc <= flush_pc;
                    if (mem_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign iq_inst  = w_head.inst;
    assign iq_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed vector table, steady-pop
// sequence and randomized traffic checked against a transaction-level model.
module tb_inst_fetcher;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pop;
    logic        flush;
    logic [31:0] flush_pc;

    always #5 clk_in = ~clk_in;

    inst_fetcher #(
        .IQ_DEPTH_LOG (3),
        .RESET_PC     (32'h0)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data),
        .iq_valid (iq_valid),
        .iq_inst  (iq_inst),
        .iq_pc    (iq_pc),
        .iq_pop   (iq_pop),
        .flush    (flush),
        .flush_pc (flush_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory controller model: answers mem_done mem_lat cycles after the request.
    int mem_lat = 3;
    int mem_cnt = 0;

    // Reference model: expected queue contents, fetch PC and the in-flight request.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_entry_t;

    exp_entry_t  m_q[$];
    bit          m_inflight;
    bit          m_discard;
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;

    typedef struct {
        logic        pop;
        logic        fl;
        logic [31:0] fpc;
        logic        rdy;
        int          cyc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight = 1'b0;
        m_discard  = 1'b0;
        m_pc       = 32'h0;
        m_req_addr = 32'h0;
        mem_done   = 1'b0;
        mem_data   = 32'h0;
        mem_cnt    = 0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        flush  = 1'b0;
        iq_pop = 1'b0;
        model_reset();
        #2;
        check("rst mem_req",  32'(mem_req),  32'h0);
        check("rst mem_addr", mem_addr,      32'h0);
        check("rst iq_valid", 32'(iq_valid), 32'h0);
        check("rst iq_inst",  iq_inst,       32'h0);
        check("rst iq_pc",    iq_pc,         32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // One clock: advance model and memory with the inputs seen at the edge, then compare.
    task automatic cycle();
        logic        e_rdy, e_flush, e_pop, e_done;
        logic [31:0] e_fpc, e_data;
        int          sz;
        e_rdy   = rdy_in;
        e_flush = flush;
        e_pop   = iq_pop;
        e_done  = mem_done;
        e_fpc   = flush_pc;
        e_data  = mem_data;
        @(posedge clk_in);
        #1;
        if (e_rdy) begin
            sz = m_q.size();
            if (e_flush) m_q.delete();
            else if (e_pop && sz > 0) void'(m_q.pop_front());
            if (m_inflight && e_done) begin
                if (!m_discard && !e_flush) begin
                    m_q.push_back('{e_data, m_req_addr});
                    m_pc = m_pc + 32'd4;
                end
                m_inflight = 1'b0;
            end else if (m_inflight) begin
                if (e_flush) m_discard = 1'b1;
            end else if (!e_flush && sz < DEPTH) begin
                m_inflight = 1'b1;
                m_discard  = 1'b0;
                m_req_addr = m_pc;
            end
            if (e_flush) m_pc = e_fpc;

            if (mem_done) begin
                mem_done = 1'b0;
                mem_cnt  = 0;
            end else if (mem_req) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_done = 1'b1;
                    mem_data = word_at(mem_addr);
                end
            end
        end
        check("mem_req", 32'(mem_req), 32'(m_inflight));
        if (m_inflight) check("mem_addr", mem_addr, m_req_addr);
        check("iq_valid", 32'(iq_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("iq_pc",   iq_pc,   m_q[0].pc);
            check("iq_inst", iq_inst, m_q[0].inst);
        end
    endtask

    initial begin
        logic [31:0] last_pc;
        int          n_pop;
        int          pop_pct;

        rdy_in   = 1'b1;
        flush    = 1'b0;
        flush_pc = 32'h0;
        iq_pop   = 1'b0;

        // Directed timeline, memory latency 3: fill, pop, flush while waiting,
        // flush with done and pop, rdy stall mid-request.
        //              pop   fl    fpc           rdy  cyc req   addr          valid head_pc
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h0,   1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 3,  1'b0, 32'h0,   1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h4,   1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 27, 1'b0, 32'h0,   1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 10, 1'b0, 32'h0,   1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1,  1'b0, 32'h0,   1'b1, 32'h4};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h20,  1'b1, 32'h4};
        vecs[7]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1,  1'b1, 32'h20,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 2,  1'b0, 32'h0,   1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h100, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 3,  1'b0, 32'h0,   1'b1, 32'h100};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h104, 1'b1, 32'h100};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 2,  1'b1, 32'h104, 1'b1, 32'h100};
        vecs[13] = '{1'b1, 1'b1, 32'h200, 1'b1, 1,  1'b0, 32'h0,   1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b1, 32'h200, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 5,  1'b1, 32'h200, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 2,  1'b1, 32'h200, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1,  1'b0, 32'h0,   1'b1, 32'h200};

        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            iq_pop   = vecs[i].pop;
            flush    = vecs[i].fl;
            flush_pc = vecs[i].fpc;
            rdy_in   = vecs[i].rdy;
            repeat (vecs[i].cyc) cycle();
            check($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d iq_valid", i), 32'(iq_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d iq_pc", i), iq_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d iq_inst", i), iq_inst, word_at(vecs[i].exp_pc));
            end
        end
        iq_pop = 1'b0;
        flush  = 1'b0;
        rdy_in = 1'b1;

        // Reset asserted while a request is outstanding.
        cycle();
        check("pre-reset mem_req", 32'(mem_req), 32'h1);
        do_reset();

        // Steady pop every cycle at latency 1: one push per two cycles, PCs strictly +4.
        mem_lat = 1;
        iq_pop  = 1'b1;
        n_pop   = 0;
        last_pc = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (iq_valid) begin
                if (n_pop == 0) check("steady first pc", iq_pc, 32'h0);
                else            check("steady pc step", iq_pc, last_pc + 32'd4);
                last_pc = iq_pc;
                n_pop++;
            end
            cycle();
        end
        check("steady pop count", 32'(n_pop), 32'd19);
        iq_pop = 1'b0;

        // Randomized traffic; reset released with rdy low first.
        rdy_in = 1'b0;
        do_reset();
        repeat (2) cycle();
        check("rdy-low no req", 32'(mem_req), 32'h0);
        rdy_in = 1'b1;
        for (int seg = 0; seg < 20; seg++) begin
            mem_lat = $urandom_range(1, 4);
            pop_pct = $urandom_range(0, 100);
            for (int c = 0; c < 150; c++) begin
                iq_pop = ($urandom_range(0, 99) < pop_pct);
                flush  = ($urandom_range(0, 99) < 3);
                case ($urandom_range(0, 3))
                    0:       flush_pc = 32'hFFFF_FFF0;
                    1:       flush_pc = $urandom;
                    default: flush_pc = $urandom & 32'h0000_FFFC;
                endcase
                rdy_in = ($urandom_range(0, 99) < 90);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
